// File: rtl/cpu_core_exec_ctrl.sv
// Execution sequencer: holds the core in reset, then runs, halts or steps it
// by gating the core clock enable, with PC breakpoint and cycle counter.
module cpu_core_exec_ctrl #(
    parameter int RST_CYCLES = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_aresetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CNT_WIDTH-1:0] cmd_arg,
    input  logic                 bp_en,
    input  logic [31:0]          bp_addr,
    input  logic [31:0]          regpc,
    output logic                 crst,
    output logic                 cen,
    output logic [1:0]           state,
    output logic [1:0]           halt_cause,
    output logic [CNT_WIDTH-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_HALTED = 2'd1,
        ST_RUN    = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_HALT  = 2'd2;
    localparam logic [1:0] OP_STEP  = 2'd3;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_STEP = 2'd1;
    localparam logic [1:0] CAUSE_BP   = 2'd2;

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES);
    localparam logic [RW-1:0] RST_LAST = RW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [RW-1:0]        rst_cnt_q, rst_cnt_d;
    logic                 crst_q, crst_d;
    logic [1:0]           cause_q, cause_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] step_q, step_d;
    logic                 skip_q, skip_d;

    logic active;
    logic bp_hit;
    logic acc;
    logic halt_req;

    assign active    = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign bp_hit    = active && bp_en && (regpc == bp_addr) && !skip_q;
    assign cen       = active && !bp_hit;
    assign acc       = cmd_valid && (state_q != ST_RST);
    assign halt_req  = acc && (cmd_op == OP_HALT);
    assign cmd_ready = (state_q != ST_RST);

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cause_d   = cause_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        skip_d    = skip_q;

        if (cen) begin
            cnt_d  = cnt_q + CNT_ONE;
            skip_d = 1'b0;
        end

        unique case (state_q)
            ST_RST: begin
                rst_cnt_d = rst_cnt_q - RST_LAST;
                if (rst_cnt_q == RST_LAST)
                    state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (acc) begin
                    unique case (1'b1)
                        cmd_op == OP_RUN: begin
                            state_d = ST_RUN;
                            cause_d = CAUSE_NONE;
                            skip_d  = 1'b1;
                        end
                        cmd_op == OP_STEP: begin
                            if (cmd_arg == '0) begin
                                cause_d = CAUSE_STEP;
                            end else begin
                                state_d = ST_STEP;
                                step_d  = cmd_arg;
                                cause_d = CAUSE_NONE;
                                skip_d  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (bp_hit) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_BP;
                end else if (halt_req) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_NONE;
                end
            end
            ST_STEP: begin
                if (cen)
                    step_d = step_q - CNT_ONE;
                if (bp_hit) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_BP;
                end else if (halt_req) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_NONE;
                end else if (cen && step_q == CNT_ONE) begin
                    state_d = ST_HALTED;
                    cause_d = CAUSE_STEP;
                end
            end
            default: state_d = ST_RST;
        endcase

        // RESET op overrides everything, including a run/step in flight
        if (acc && cmd_op == OP_RESET) begin
            state_d   = ST_RST;
            rst_cnt_d = RST_LOAD;
            cause_d   = CAUSE_NONE;
            cnt_d     = '0;
            step_d    = '0;
            skip_d    = 1'b0;
        end

        crst_d = (state_d == ST_RST);
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_q   <= ST_RST;
            rst_cnt_q <= RST_LOAD;
            crst_q    <= 1'b1;
            cause_q   <= CAUSE_NONE;
            cnt_q     <= '0;
            step_q    <= '0;
            skip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            crst_q    <= crst_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            skip_q    <= skip_d;
        end
    end

    assign crst       = crst_q;
    assign state      = state_q;
    assign halt_cause = cause_q;
    assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_cpu_core_exec_ctrl.sv
// Directed bench for cpu_core_exec_ctrl: reset, step, run/halt, breakpoints,
// RESET op and counter wrap (small-width instance).
module tb_cpu_core_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] regpc;
    logic        crst;
    logic        cen;
    logic [1:0]  state;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_cnt;

    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_op;
    logic [3:0]  s_arg;
    logic        s_bp_en;
    logic [31:0] s_bp_addr;
    logic [31:0] s_regpc;
    logic        s_crst;
    logic        s_cen;
    logic [1:0]  s_state;
    logic [1:0]  s_cause;
    logic [3:0]  s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_core_exec_ctrl #(.RST_CYCLES(16), .CNT_WIDTH(32)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_arg       (cmd_arg),
        .bp_en         (bp_en),
        .bp_addr       (bp_addr),
        .regpc         (regpc),
        .crst          (crst),
        .cen           (cen),
        .state         (state),
        .halt_cause    (halt_cause),
        .cycle_cnt     (cycle_cnt)
    );

    cpu_core_exec_ctrl #(.RST_CYCLES(2), .CNT_WIDTH(4)) u_small (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .cmd_valid     (s_valid),
        .cmd_ready     (s_ready),
        .cmd_op        (s_op),
        .cmd_arg       (s_arg),
        .bp_en         (s_bp_en),
        .bp_addr       (s_bp_addr),
        .regpc         (s_regpc),
        .crst          (s_crst),
        .cen           (s_cen),
        .state         (s_state),
        .halt_cause    (s_cause),
        .cycle_cnt     (s_cnt)
    );

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_small(input logic [1:0] op, input logic [3:0] arg);
        s_valid = 1'b1;
        s_op    = op;
        s_arg   = arg;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++; $display("FAIL rst_state: got %0d want 0", state);
        end
        n_checks++;
        if (crst !== 1'b1 || cen !== 1'b0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_outs: crst=%b cen=%b rdy=%b want 1 0 0",
                     crst, cen, cmd_ready);
        end
        n_checks++;
        if (cycle_cnt !== 32'd0 || halt_cause !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_cnt: cnt=%0d cause=%0d want 0 0",
                     cycle_cnt, halt_cause);
        end
        rst_n = 1'b1;
        n = 0;
        while (crst === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != 16) begin
            n_fail++; $display("FAIL rst_len: got %0d want 16", n);
        end
        n_checks++;
        if (state !== 2'd1 || cmd_ready !== 1'b1 || cen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_exit: st=%0d rdy=%b cen=%b want 1 1 0",
                     state, cmd_ready, cen);
        end
    endtask

    task automatic test_step5;
        int n;
        int k;
        send_cmd(2'd3, 32'd5);
        n = 0;
        k = 0;
        while (state !== 2'd1 && k < 50) begin
            if (cen === 1'b1) n++;
            k++;
            @(negedge clk);
        end
        n_checks++;
        if (n != 5) begin
            n_fail++; $display("FAIL step5_cen: got %0d want 5", n);
        end
        n_checks++;
        if (cycle_cnt !== 32'd5 || halt_cause !== 2'd1) begin
            n_fail++;
            $display("FAIL step5_end: cnt=%0d cause=%0d want 5 1",
                     cycle_cnt, halt_cause);
        end
    endtask

    task automatic test_breakpoint;
        int n;
        int k;
        logic e;
        bp_en   = 1'b1;
        bp_addr = 32'h100;
        regpc   = 32'hF0;
        send_cmd(2'd1, 32'd0);
        n = 0;
        k = 0;
        while (regpc != 32'h100 && k < 50) begin
            e = cen;
            if (e) n++;
            k++;
            @(posedge clk);
            #1;
            if (e) regpc = regpc + 32'd4;
            @(negedge clk);
        end
        n_checks++;
        if (cen !== 1'b0 || n != 4) begin
            n_fail++;
            $display("FAIL bp_hit: cen=%b ncen=%0d want 0 4", cen, n);
        end
        @(negedge clk);
        n_checks++;
        if (state !== 2'd1 || halt_cause !== 2'd2 || cycle_cnt !== 32'd9) begin
            n_fail++;
            $display("FAIL bp_halt: st=%0d cause=%0d cnt=%0d want 1 2 9",
                     state, halt_cause, cycle_cnt);
        end
        send_cmd(2'd1, 32'd0);
        n_checks++;
        if (cen !== 1'b1 || state !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_skip: cen=%b st=%0d want 1 2", cen, state);
        end
        @(posedge clk);
        #1;
        regpc = regpc + 32'd4;
        @(negedge clk);
        n_checks++;
        if (cen !== 1'b1 || state !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_cont: cen=%b st=%0d want 1 2", cen, state);
        end
        send_cmd(2'd2, 32'd0);
        n_checks++;
        if (state !== 2'd1 || halt_cause !== 2'd0 || cycle_cnt !== 32'd11) begin
            n_fail++;
            $display("FAIL bp_host: st=%0d cause=%0d cnt=%0d want 1 0 11",
                     state, halt_cause, cycle_cnt);
        end
    endtask

    task automatic test_step_bp;
        int n;
        int k;
        logic e;
        bp_addr = 32'h200;
        regpc   = 32'h1FC;
        send_cmd(2'd3, 32'd3);
        n = 0;
        k = 0;
        while (state !== 2'd1 && k < 50) begin
            e = cen;
            if (e) n++;
            k++;
            @(posedge clk);
            #1;
            if (e) regpc = regpc + 32'd4;
            @(negedge clk);
        end
        n_checks++;
        if (n != 1 || halt_cause !== 2'd2 || cycle_cnt !== 32'd12) begin
            n_fail++;
            $display("FAIL step_bp: ncen=%0d cause=%0d cnt=%0d want 1 2 12",
                     n, halt_cause, cycle_cnt);
        end
        send_cmd(2'd3, 32'd0);
        n_checks++;
        if (state !== 2'd1 || halt_cause !== 2'd1 || cen !== 1'b0 ||
            cycle_cnt !== 32'd12) begin
            n_fail++;
            $display("FAIL step0: st=%0d cause=%0d cen=%b cnt=%0d want 1 1 0 12",
                     state, halt_cause, cen, cycle_cnt);
        end
    endtask

    task automatic test_reset_op;
        int n;
        logic bad;
        bp_en = 1'b0;
        send_cmd(2'd3, 32'd100);
        repeat (3) @(negedge clk);
        send_cmd(2'd0, 32'd0);
        n_checks++;
        if (state !== 2'd0 || crst !== 1'b1 || cycle_cnt !== 32'd0 ||
            cen !== 1'b0) begin
            n_fail++;
            $display("FAIL rop_entry: st=%0d crst=%b cnt=%0d cen=%b want 0 1 0 0",
                     state, crst, cycle_cnt, cen);
        end
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        bad = 1'b0;
        n = 0;
        while (crst === 1'b1 && n < 100) begin
            if (cmd_ready !== 1'b0) bad = 1'b1;
            n++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (n != 16 || bad !== 1'b0) begin
            n_fail++;
            $display("FAIL rop_len: n=%0d rdy_seen=%b want 16 0", n, bad);
        end
        @(negedge clk);
        n_checks++;
        if (state !== 2'd1 || cycle_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL rop_exit: st=%0d cnt=%0d want 1 0", state, cycle_cnt);
        end
    endtask

    task automatic test_back_to_back;
        send_cmd(2'd1, 32'd0);
        repeat (4) @(negedge clk);
        send_cmd(2'd1, 32'd0);
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++; $display("FAIL run_noop: st=%0d want 2", state);
        end
        repeat (5) @(negedge clk);
        send_cmd(2'd2, 32'd0);
        n_checks++;
        if (cycle_cnt !== 32'd11 || state !== 2'd1 || halt_cause !== 2'd0 ||
            cen !== 1'b0) begin
            n_fail++;
            $display("FAIL run_halt: cnt=%0d st=%0d cause=%0d cen=%b want 11 1 0 0",
                     cycle_cnt, state, halt_cause, cen);
        end
    endtask

    task automatic test_wrap;
        int k;
        int n;
        send_small(2'd1, 4'd0);
        k = 0;
        while (s_cnt !== 4'hF && k < 40) begin
            k++;
            @(negedge clk);
        end
        n_checks++;
        if (s_cnt !== 4'hF || s_cen !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_top: cnt=%0h cen=%b want f 1", s_cnt, s_cen);
        end
        @(negedge clk);
        n_checks++;
        if (s_cnt !== 4'h0 || s_state !== 2'd2) begin
            n_fail++;
            $display("FAIL wrap_zero: cnt=%0h st=%0d want 0 2", s_cnt, s_state);
        end
        repeat (2) @(negedge clk);
        send_small(2'd0, 4'd0);
        n_checks++;
        if (s_cnt !== 4'h0 || s_state !== 2'd0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_rst: cnt=%0h st=%0d rdy=%b want 0 0 0",
                     s_cnt, s_state, s_ready);
        end
        n = 0;
        while (s_crst === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != 2 || s_state !== 2'd1) begin
            n_fail++;
            $display("FAIL wrap_rlen: n=%0d st=%0d want 2 1", n, s_state);
        end
    endtask

    task automatic test_hw_reset;
        send_cmd(2'd1, 32'd0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (cen !== 1'b1) begin
            n_fail++; $display("FAIL hw_pre: cen=%b want 1", cen);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (state !== 2'd0 || crst !== 1'b1 || cen !== 1'b0 ||
            cycle_cnt !== 32'd0 || cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hw_rst: st=%0d crst=%b cen=%b cnt=%0d rdy=%b want 0 1 0 0 0",
                     state, crst, cen, cycle_cnt, cmd_ready);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_arg   = 32'd0;
        bp_en     = 1'b0;
        bp_addr   = 32'd0;
        regpc     = 32'd0;
        s_valid   = 1'b0;
        s_op      = 2'd0;
        s_arg     = 4'd0;
        s_bp_en   = 1'b0;
        s_bp_addr = 32'd0;
        s_regpc   = 32'd0;
        repeat (3) @(negedge clk);
        test_reset;
        test_step5;
        test_breakpoint;
        test_step_bp;
        test_reset_op;
        test_back_to_back;
        test_wrap;
        test_hw_reset;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
